// File: rtl/irq_pending_latch_pkg.sv
// rtl/irq_pending_latch_pkg.sv - shared sizes and FSM encodings for the irq pending latch
package irq_pending_latch_pkg;

    localparam int IRQ_N   = 8;
    localparam int IRQ_IDW = 3;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_SERVICE = 1'b1;

endpackage

// File: rtl/irq_line_cell.sv
// rtl/irq_line_cell.sv - per-line synchroniser, edge/level capture, pending and overflow (IRQ_SYNC_EN)
module irq_line_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    input  logic edge_mode,
    input  logic clr_i,
    output logic pending_i,
    output logic overflow_i
);

    logic s;
    logic s_d;
    logic rise;
    logic set_i;

`ifdef IRQ_SYNC_EN
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            s    <= 1'b0;
        end else begin
            meta <= irq_in;
            s    <= meta;
        end
    end
`else
    assign s = irq_in;
`endif

    assign rise  = s & ~s_d;
    assign set_i = edge_mode ? rise : s;

    // Set beats clear so a request arriving on the ack cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d        <= 1'b0;
            pending_i  <= 1'b0;
            overflow_i <= 1'b0;
        end else begin
            s_d <= s;
            if (set_i) begin
                pending_i <= 1'b1;
            end else if (clr_i) begin
                pending_i <= 1'b0;
            end
            if (edge_mode && rise && pending_i && !clr_i) begin
                overflow_i <= 1'b1;
            end else if (clr_i) begin
                overflow_i <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - pending latch, gating and ack/eoi service FSM feeding the 8-to-3 encoder (IRQ_SYNC_EN)
module irq_pending_latch
    import irq_pending_latch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IRQ_N-1:0]   irq_in,
    input  logic [IRQ_N-1:0]   edge_mode,
    input  logic [IRQ_N-1:0]   mask,
    output logic [IRQ_N-1:0]   pend_out,
    output logic               irq_valid,
    input  logic               ack,
    input  logic [IRQ_IDW-1:0] ack_id,
    input  logic               eoi,
    output logic               in_service,
    output logic [IRQ_IDW-1:0] isr_id,
    output logic [IRQ_N-1:0]   overflow,
    output logic               spurious_ack
);

    logic [0:0]       state;
    logic [IRQ_N-1:0] pending;
    logic [IRQ_N-1:0] clr;
    logic             accept;

    for (genvar i = 0; i < IRQ_N; i++) begin : g_line
        irq_line_cell u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .irq_in     (irq_in[i]),
            .edge_mode  (edge_mode[i]),
            .clr_i      (clr[i]),
            .pending_i  (pending[i]),
            .overflow_i (overflow[i])
        );
    end

    assign pend_out   = (state == ST_IDLE) ? (pending & mask) : '0;
    assign irq_valid  = |pend_out;
    assign in_service = (state == ST_SERVICE);

    // Only a request actually visible to the encoder can be taken.
    assign accept = (state == ST_IDLE) && ack && pend_out[ack_id];
    assign clr    = accept ? (IRQ_N'(1) << ack_id) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            isr_id       <= '0;
            spurious_ack <= 1'b0;
        end else begin
            spurious_ack <= ack && !accept;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        isr_id <= ack_id;
                        state  <= ST_SERVICE;
                    end
                end
                default: begin
                    if (eoi) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
